// File: rtl/gal_array.sv
// Purpose : configurable GAL-style AND/OR array with M macrocells, serial double-buffered config.
// Latency : combinational macrocells 0 cycles in_vars->out_vals, registered macrocells 1 cycle.
// Backpressure: none; config shifts whenever cfg_en=1, and an apply is accepted or rejected in one cycle.
//
// Ports:
//   clk, res_n      - rising-edge clock, asynchronous active-low reset
//   cfg_en, cfg_in  - serial shift into the shadow config (enters at the top index)
//   cfg_apply       - commit shadow to active (valid only after exactly CFG_LEN shifts)
//   run_en          - clock enable for the macrocell registers Q
//   in_vars         - N logic inputs
//   out_vals        - M macrocell outputs (forced to 0 while no config is active)
//   cfg_out         - serial chain tail (shadow[0]) when GAL_CFG_READBACK_EN is defined, else 0
//   cfg_valid       - an active config is loaded
//   cfg_err         - the most recent apply was rejected
//
// Config layout (index ascending): AND plane (term p at [2Kp +: 2K], bit 2k true literal,
// bit 2k+1 complement; variables k>=N are feedback Q[k-N]), OR plane (output m at
// [2KP+Pm +: P]), M mode bits (1=registered), M polarity bits (1=invert).
// Optional feature macro: GAL_CFG_READBACK_EN.
module gal_array #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 14
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         cfg_en,
  input  logic         cfg_in,
  input  logic         cfg_apply,
  input  logic         run_en,
  input  logic [N-1:0] in_vars,
  output logic [M-1:0] out_vals,
  output logic         cfg_out,
  output logic         cfg_valid,
  output logic         cfg_err
);

  localparam int K         = N + M;
  localparam int OR_BASE   = 2 * K * P;
  localparam int MODE_BASE = OR_BASE + P * M;
  localparam int POL_BASE  = MODE_BASE + M;
  localparam int CFG_LEN   = POL_BASE + M;
  localparam int CW        = $clog2(CFG_LEN + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

  logic [CFG_LEN-1:0] shadow;
  logic [CFG_LEN-1:0] active;
  logic [CW-1:0]      shift_cnt;
  logic [M-1:0]       q;

  logic               apply_ok;
  logic [K-1:0]       vars;
  logic [2*K-1:0]     lit;
  logic [P-1:0]       term;
  logic [M-1:0]       sum;
  logic [M-1:0]       mode;
  logic [M-1:0]       pol;

  // An apply is only honoured on a quiet chain holding exactly one full config.
  assign apply_ok = cfg_apply && !cfg_en && (shift_cnt == CNT_FULL);

  // Shadow chain and shift counter. The counter parks one past full so that
  // over-shifting is distinguishable from an exact load.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shadow    <= '0;
      shift_cnt <= '0;
    end else begin
      if (cfg_en) begin
        shadow <= {cfg_in, shadow[CFG_LEN-1:1]};
      end
      if (cfg_apply) begin
        shift_cnt <= '0;
      end else if (cfg_en && (shift_cnt != CNT_SAT)) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

  // Active config and status flags.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (cfg_apply) begin
      if (apply_ok) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
    end
  end

  // Macrocell registers; a fresh config always starts from Q=0.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q <= '0;
    end else if (apply_ok) begin
      q <= '0;
    end else if (run_en && cfg_valid) begin
      q <= sum;
    end
  end

  // Feedback taps Q only, never sum, so the array has no combinational loop.
  assign vars = {q, in_vars};

  always_comb begin
    lit = '0;
    for (int k = 0; k < K; k++) begin
      lit[2*k]   = vars[k];
      lit[2*k+1] = ~vars[k];
    end
  end

  // A term with no selected literal would AND to 1; force it to 0 instead.
  always_comb begin
    term = '0;
    for (int p = 0; p < P; p++) begin
      term[p] = (|active[2*K*p +: 2*K]) & (&(lit | ~active[2*K*p +: 2*K]));
    end
  end

  always_comb begin
    sum = '0;
    for (int m = 0; m < M; m++) begin
      sum[m] = |(term & active[OR_BASE + P*m +: P]);
    end
  end

  assign mode = active[MODE_BASE +: M];
  assign pol  = active[POL_BASE +: M];

  assign out_vals = cfg_valid ? (pol ^ ((mode & q) | (~mode & sum))) : '0;

`ifdef GAL_CFG_READBACK_EN
  assign cfg_out = shadow[0];
`else
  assign cfg_out = 1'b0;
`endif

endmodule

// File: tb/tb_gal_array.sv
module tb_gal_array;

  localparam int N = 8;
  localparam int M = 4;
  localparam int P = 14;
  localparam int L = 400;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         cfg_en = 1'b0;
  logic         cfg_in = 1'b0;
  logic         cfg_apply = 1'b0;
  logic         run_en = 1'b0;
  logic [N-1:0] in_vars = '0;
  logic [M-1:0] out_vals;
  logic         cfg_out;
  logic         cfg_valid;
  logic         cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [L-1:0] cfg_a, cfg_b, cfg_t, pat, rb;

  gal_array #(.N(N), .M(M), .P(P)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .cfg_en    (cfg_en),
    .cfg_in    (cfg_in),
    .cfg_apply (cfg_apply),
    .run_en    (run_en),
    .in_vars   (in_vars),
    .out_vals  (out_vals),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [L-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_in = v[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
  endtask

  task automatic set_in(input logic [N-1:0] v);
    in_vars = v;
    #1;
  endtask

  initial begin
    // Bit map at defaults (K=12): term0 at [0+:24], OR0 at 336, mode0 at 392, pol m at 396+m.
    cfg_a = '0;
    cfg_a[0]   = 1'b1;   // in_vars[0]
    cfg_a[2]   = 1'b1;   // in_vars[1]
    cfg_a[336] = 1'b1;   // OR0 <- term0
    cfg_b = cfg_a;
    cfg_b[392] = 1'b1;   // output 0 registered
    cfg_b[397] = 1'b1;   // output 1 inverted (sum1 = 0, so constant 1)
    cfg_t = '0;
    cfg_t[17]  = 1'b1;   // ~Q0 (variable 8 complement)
    cfg_t[336] = 1'b1;
    cfg_t[392] = 1'b1;
    pat = {25{16'hA5C3}};

    // Reset state
    #12;
    check("rst_out", 32'(out_vals), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    check("rst_cfg_out", 32'(cfg_out), 32'h0);
    res_n = 1'b1;
    tick();

    // Short load rejected, then a full load accepted
    shift_bits(cfg_a, L - 1);
    apply();
    set_in(8'h03);
    check("short_err", 32'(cfg_err), 32'h1);
    check("short_valid", 32'(cfg_valid), 32'h0);
    check("short_out", 32'(out_vals), 32'h0);
    shift_bits(cfg_a, L);
    apply();
    check("full_err", 32'(cfg_err), 32'h0);
    check("full_valid", 32'(cfg_valid), 32'h1);

    // Combinational AND of in0 & in1
    set_in(8'h03); check("comb_03", 32'(out_vals), 32'h1);
    set_in(8'h01); check("comb_01", 32'(out_vals), 32'h0);
    set_in(8'hFF); check("comb_FF", 32'(out_vals), 32'h1);
    set_in(8'h02); check("comb_02", 32'(out_vals), 32'h0);

    // Over-shift (401 bits) rejected without disturbing the active function
    shift_bits(cfg_a, L);
    shift_bits(cfg_a, 1);
    apply();
    set_in(8'h03);
    check("over_err", 32'(cfg_err), 32'h1);
    check("over_valid", 32'(cfg_valid), 32'h1);
    check("over_out", 32'(out_vals), 32'h1);

    // New pattern shifted without apply: active logic untouched
    shift_bits(cfg_b, L);
    set_in(8'h03); check("dbuf_03", 32'(out_vals), 32'h1);
    set_in(8'h01); check("dbuf_01", 32'(out_vals), 32'h0);

`ifndef GAL_CFG_READBACK_EN
    check("cfg_out_tied", 32'(cfg_out), 32'h0);
`endif

    // Apply: registered output 0 starts from Q=0, output 1 inverted
    apply();
    check("regd_err", 32'(cfg_err), 32'h0);
    set_in(8'h03);
    check("regd_init", 32'(out_vals), 32'h2);
    run_en = 1'b1;
    tick();
    check("regd_q1", 32'(out_vals), 32'h3);
    set_in(8'h01);
    check("regd_before_edge", 32'(out_vals), 32'h3);
    tick();
    check("regd_q0", 32'(out_vals), 32'h2);
    run_en = 1'b0;
    set_in(8'h03);
    tick(); tick();
    check("regd_hold", 32'(out_vals), 32'h2);

    // Apply while shifting is rejected, config stays, the shift still happens
    cfg_en = 1'b1; cfg_in = 1'b1; cfg_apply = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_in = 1'b0; cfg_apply = 1'b0;
    check("shift_apply_err", 32'(cfg_err), 32'h1);
    check("shift_apply_valid", 32'(cfg_valid), 32'h1);
    run_en = 1'b1;
    tick();
    check("shift_apply_func", 32'(out_vals), 32'h3);
    run_en = 1'b0;

    // Toggle flip-flop through Q0 feedback
    shift_bits(cfg_t, L);
    apply();
    check("tog_0", 32'(out_vals), 32'h0);
    run_en = 1'b1;
    tick(); check("tog_1", 32'(out_vals), 32'h1);
    tick(); check("tog_2", 32'(out_vals), 32'h0);
    tick(); check("tog_3", 32'(out_vals), 32'h1);
    #2;
    res_n = 1'b0;
    #1;
    check("arst_out", 32'(out_vals), 32'h0);
    check("arst_valid", 32'(cfg_valid), 32'h0);
    tick();
    res_n = 1'b1;
    run_en = 1'b0;

    // Partial load interrupted by reset is discarded
    shift_bits(cfg_a, 200);
    res_n = 1'b0; #1; res_n = 1'b1;
    shift_bits(cfg_a, 200);
    apply();
    check("partial_err", 32'(cfg_err), 32'h1);
    check("partial_valid", 32'(cfg_valid), 32'h0);

`ifdef GAL_CFG_READBACK_EN
    // Readback: the loaded bits reappear at cfg_out in the order sent
    shift_bits(pat, L);
    rb = '0;
    for (int i = 0; i < L; i++) begin
      rb[i] = cfg_out;
      cfg_en = 1'b1;
      cfg_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
    check("readback_lo", rb[31:0], pat[31:0]);
    check("readback_hi", rb[399:368], pat[399:368]);
    check("readback_all", 32'(rb == pat), 32'h1);
`else
    shift_bits(pat, L);
    check("no_readback", 32'(cfg_out), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gal_array.md
GAL_ARRAY -- requirements
Module: gal_array

Interface
REQ-001 SHALL have parameter N, default 8: number of input variables.
REQ-002 SHALL have parameter M, default 4: number of output macrocells.
REQ-003 SHALL have parameter P, default 14: number of product terms.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state on its rising edge.
REQ-005 SHALL have port res_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_en, input, 1: shift enable for the config chain.
REQ-007 SHALL have port cfg_in, input, 1: serial config bit.
REQ-008 SHALL have port cfg_apply, input, 1: single-cycle request to commit the shadow config to active.
REQ-009 SHALL have port run_en, input, 1: clock enable for the macrocell registers.
REQ-010 SHALL have port in_vars, input, N: logic inputs.
REQ-011 SHALL have port out_vals, output, M: macrocell outputs.
REQ-012 SHALL have port cfg_out, output, 1: serial chain tail (readback/daisy-chain).
REQ-013 SHALL have port cfg_valid, output, 1: active config loaded.
REQ-014 SHALL have port cfg_err, output, 1: last apply rejected.

Function
REQ-015 SHALL define K=N+M and CFG_LEN=2KP+PM+2M (400 at defaults).
REQ-016 Layout, index ascending: AND plane (term p at [2Kp +: 2K]; bit 2k = true literal, bit 2k+1 = complement of variable k; k<N is in_vars[k], k>=N is feedback Q[k-N]); OR plane (output m at [2KP+Pm +: P]); M mode bits (1=registered); M polarity bits (1=invert).
REQ-017 cfg_en=1: shadow SHALL shift right by one per cycle, cfg_in entering index CFG_LEN-1; after CFG_LEN shifts the first bit sent sits at index 0.
REQ-018 A shift counter SHALL count shifts, saturating at CFG_LEN+1 (overflow).
REQ-019 cfg_apply=1 with cfg_en=0 and count==CFG_LEN: active<=shadow, cfg_valid<=1, cfg_err<=0, count<=0, registers Q<=0; visible the next cycle.
REQ-020 cfg_apply=1 with count!=CFG_LEN, or in the same cycle as cfg_en=1: active unchanged, cfg_err<=1, count<=0; a simultaneous shift still occurs.
REQ-021 Product term SHALL be the AND of selected literals; a term with no literals selected SHALL be 0.
REQ-022 sum[m] SHALL be the OR of the selected terms; 0 if none are selected.
REQ-023 Q[m]<=sum[m] on each clock with run_en=1 and cfg_valid=1; otherwise Q holds.
REQ-024 out_vals[m] = polarity[m] XOR (mode[m] ? Q[m] : sum[m]): 0-cycle latency combinational, 1-cycle registered.
REQ-025 out_vals SHALL be 0 while cfg_valid=0, regardless of polarity.
REQ-026 Feedback SHALL always come from Q, never from the combinational sum, so no combinational loop exists.
REQ-027 Shifting while cfg_valid=1 SHALL NOT disturb active logic (double-buffered).

Reset
REQ-028 res_n=0 SHALL asynchronously clear shadow, active, Q, counter, cfg_valid and cfg_err; out_vals=0 and cfg_out=0.
REQ-029 Reset asserted mid-shift SHALL discard the partial load; after release, a full CFG_LEN load plus apply is required.

Configuration
REQ-030 Macro GAL_CFG_READBACK_EN defined: cfg_out = shadow[0], the bit shifted out each cycle, allowing daisy-chaining and readback.
REQ-031 Macro undefined: cfg_out SHALL be tied to 0 and no readback logic is built; all other behaviour is identical.

Verification (defaults N=8, M=4, P=14, CFG_LEN=400)
REQ-032 Load 400 bits: term0 = in_vars[0]&in_vars[1], OR0 = term0, mode0=0, pol0=0; apply; in_vars=8'h03 -> out_vals[0]=1 in the same cycle; in_vars=8'h01 -> 0.
REQ-033 Same load with mode0=1, run_en=1 -> out_vals[0] follows in_vars one clock later; run_en=0 -> holds.
REQ-034 Shift 399 bits then apply -> cfg_err=1, cfg_valid stays 0, out_vals=0; shift 400 more then apply -> cfg_err=0, cfg_valid=1.
REQ-035 cfg_valid=1; shift a new pattern without apply -> out_vals unchanged; apply -> new function the next cycle.
REQ-036 Toggle flip-flop via feedback (term0 = ~Q0, registered), run_en=1 -> out_vals[0] toggles 0,1,0,1; res_n pulse mid-run -> out_vals=0 and cfg_valid=0 immediately.
REQ-037 With GAL_CFG_READBACK_EN: shift 400 known bits, then shift 400 zeros -> cfg_out reproduces the original 400 bits in order.
